irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 Port: rst  input  1  reset; synchronous, active-high.
REQ-003 Port: addr  input  32  bus register address.
REQ-004 Port: wdata  input  32  bus write data.
REQ-005 Port: wr_en  input  1  bus write strobe, one cycle per write.
REQ-006 Port: rdata  output  32  combinational read data for addr.
REQ-007 Port: irq_src  input  8  level interrupt sources; bit 0 = timer interrupt (tim_int), bits 7:1 other peripherals.
REQ-008 Port: irq_req  output  1  interrupt request to core, registered.
REQ-009 Port: irq_id  output  3  source index of the request, registered.
REQ-010 Port: irq_ack  input  1  core accepts the request, one-cycle pulse.

Function
REQ-011 Register map, 32-bit words: IPR 0x20000020 (RO, bits 7:0 pending), IER 0x20000024 (RW, bits 7:0 enable), ISTAT 0x20000028 (RO, bits 1:0 FSM state, bits 6:4 active id), IEOI 0x2000002C (WO, wdata[2:0] = id to complete).
REQ-012 Unmapped addresses: rdata = 0; writes ignored; unused register bits read 0.
REQ-013 IER updated with wdata[7:0] at the edge where wr_en=1 and addr=0x20000024.
REQ-014 Pending register: each cycle pend[i] <= irq_src[i] & ier[i]; not sticky, so a source clears by deasserting irq_src.
REQ-015 FSM states: IDLE=2'b00, REQ=2'b01, ACTIVE=2'b10; 2'b11 unreachable, decodes as IDLE next cycle.
REQ-016 IDLE: if pend != 0, latch irq_id = lowest set index (bit 0 highest priority) and go to REQ; otherwise stay.
REQ-017 REQ: irq_req = 1; irq_id held stable; no retraction even if pend[irq_id] drops; on irq_ack=1 go to ACTIVE.
REQ-018 ACTIVE: irq_req = 0; irq_id keeps the active id; no new request is raised (no nesting).
REQ-019 ACTIVE exits to IDLE only on a write to IEOI with wdata[2:0] == irq_id; a mismatched id is ignored.
REQ-020 IEOI writes in IDLE or REQ are ignored; irq_ack in IDLE or ACTIVE is ignored.
REQ-021 Latency: irq_src[i] high with ier[i]=1 before edge E1 gives pend at E1, state REQ at E2, and irq_req=1 visible after E2, i.e. 2 cycles.
REQ-022 Back-to-back: after EOI at edge E, IDLE re-evaluates pend at E+1; irq_req rises again after E+1 if any pend is set.
REQ-023 An IER write clearing an enable does not withdraw a request already in REQ.
REQ-024 A simultaneous IER write and pend change resolve using the old ier value for that cycle (registered update).

Reset
REQ-025 While rst=1 at a rising edge: state=IDLE, ier=0, pend=0, irq_req=0, irq_id=0.
REQ-026 Reset mid-operation in REQ or ACTIVE abandons the interrupt with no EOI required; irq_req=0 after the next edge.
REQ-027 rdata reflects reset register values: IPR=0, IER=0, ISTAT=0.

Verification
REQ-028 Scenario: IER=0x01, irq_src=0x01 -> irq_req=1, irq_id=0 two cycles later; IPR reads 0x01.
REQ-029 Scenario: IER=0xFF, irq_src=0xA4 -> irq_id=2; ack, then EOI wdata=2 with src still 0xA4 -> irq_id=2 again; drop bit 2 first -> irq_id=5.
REQ-030 Scenario: in ACTIVE with id=3, EOI wdata=4 -> ISTAT state stays 2'b10; then EOI wdata=3 -> IDLE next cycle.
REQ-031 Scenario: IER=0x00, irq_src=0xFF -> irq_req stays 0, IPR=0; write IER=0x80 -> irq_id=7 two cycles later.
REQ-032 Scenario: in REQ, drop irq_src -> irq_req held at 1 until irq_ack; rst=1 in ACTIVE -> irq_req=0, IER=0, ISTAT=0.
REQ-033 Scenario: irq_ack pulsed in IDLE and IEOI written in REQ -> no state change.

Source files
------------

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : Eight-source level interrupt controller with a memory-mapped
//               register file (IPR/IER/ISTAT/IEOI), fixed priority (bit 0
//               highest) and a non-nesting IDLE -> REQ -> ACTIVE handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    output logic [31:0] rdata,
    input  logic [7:0]  irq_src,
    output logic        irq_req,
    output logic [2:0]  irq_id,
    input  logic        irq_ack
);

    localparam logic [31:0] c_addr_ipr   = 32'h2000_0020;
    localparam logic [31:0] c_addr_ier   = 32'h2000_0024;
    localparam logic [31:0] c_addr_istat = 32'h2000_0028;
    localparam logic [31:0] c_addr_ieoi  = 32'h2000_002C;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_REQ     = 2'b01,
        S_ACTIVE  = 2'b10,
        S_ILLEGAL = 2'b11
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_ier;
    logic [7:0]  r_pend;
    logic [2:0]  r_irq_id;
    logic [2:0]  w_irq_id_next;
    logic        r_irq_req;
    logic [2:0]  w_lowest;
    logic        w_ier_wr;
    logic        w_eoi_wr;

    // Upper write-data bits carry no register content.
    logic        w_unused_wdata;
    assign w_unused_wdata = ^wdata[31:8];

    assign w_ier_wr = wr_en && (addr == c_addr_ier);
    assign w_eoi_wr = wr_en && (addr == c_addr_ieoi);

    // Enable register: written from the bus, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ier <= 8'h00;
        end else if (w_ier_wr) begin
            r_ier <= wdata[7:0];
        end
    end

    // Pending is a registered, non-sticky mask of the sources; it sees the
    // enable value from before any same-cycle IER write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= 8'h00;
        end else begin
            r_pend <= irq_src & r_ier;
        end
    end

    // Fixed-priority encoder: the lowest set pending bit wins.
    always_comb begin
        w_lowest = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_lowest = 3'(i);
            end
        end
    end

    // Handshake FSM next-state: request, core acknowledge, then wait for a
    // matching end-of-interrupt before re-arbitrating.
    always_comb begin
        w_state_next  = r_state;
        w_irq_id_next = r_irq_id;
        case (r_state)
            S_IDLE: begin
                if (r_pend != 8'h00) begin
                    w_state_next  = S_REQ;
                    w_irq_id_next = w_lowest;
                end
            end
            S_REQ: begin
                if (irq_ack) begin
                    w_state_next = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (w_eoi_wr && (wdata[2:0] == r_irq_id)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, latched id and the registered request output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_irq_id  <= 3'd0;
            r_irq_req <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_irq_id  <= w_irq_id_next;
            r_irq_req <= (w_state_next == S_REQ);
        end
    end

    assign irq_req = r_irq_req;
    assign irq_id  = r_irq_id;

    // Combinational register read mux; unmapped addresses return zero.
    always_comb begin
        rdata = 32'h0000_0000;
        case (addr)
            c_addr_ipr:   rdata = {24'h000000, r_pend};
            c_addr_ier:   rdata = {24'h000000, r_ier};
            c_addr_istat: rdata = {25'd0, r_irq_id, 2'b00, r_state};
            default:      rdata = 32'h0000_0000;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_ctrl
// Description : Directed self-checking bench for irq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

    localparam logic [31:0] c_ipr   = 32'h2000_0020;
    localparam logic [31:0] c_ier   = 32'h2000_0024;
    localparam logic [31:0] c_istat = 32'h2000_0028;
    localparam logic [31:0] c_ieoi  = 32'h2000_002C;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr_en;
    logic [31:0] rdata;
    logic [7:0]  irq_src;
    logic        irq_req;
    logic [2:0]  irq_id;
    logic        irq_ack;

    int total = 0;
    int bad   = 0;

    irq_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .wdata   (wdata),
        .wr_en   (wr_en),
        .rdata   (rdata),
        .irq_src (irq_src),
        .irq_req (irq_req),
        .irq_id  (irq_id),
        .irq_ack (irq_ack)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
        addr = 32'h0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b exp=0", irq_req); end
        total++; if (irq_id !== 3'd0) begin bad++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
        bus_read(c_ipr, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_ipr got=%h exp=0", d); end
        bus_read(c_ier, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_ier got=%h exp=0", d); end
        bus_read(c_istat, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_istat got=%h exp=0", d); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        bus_write(32'h2000_0034, 32'hFF);
        bus_write(c_ipr, 32'hFF);
        bus_read(c_ier, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_write_ier got=%h exp=0", d); end
        bus_read(32'h2000_0030, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h exp=0", d); end
    endtask

    task automatic test_single();
        logic [31:0] d;
        bus_write(c_ier, 32'h01);
        irq_src = 8'h01;
        tick();
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL single_lat1 got=%0b exp=0", irq_req); end
        tick();
        total++; if (irq_req !== 1'b1) begin bad++; $display("FAIL single_req got=%0b exp=1", irq_req); end
        total++; if (irq_id !== 3'd0) begin bad++; $display("FAIL single_id got=%0d exp=0", irq_id); end
        bus_read(c_ipr, d);
        total++; if (d !== 32'h01) begin bad++; $display("FAIL single_ipr got=%h exp=01", d); end
        bus_read(c_istat, d);
        total++; if (d !== 32'h01) begin bad++; $display("FAIL single_istat_req got=%h exp=01", d); end
        pulse_ack();
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL single_ack_req got=%0b exp=0", irq_req); end
        bus_read(c_istat, d);
        total++; if (d !== 32'h02) begin bad++; $display("FAIL single_istat_act got=%h exp=02", d); end
        irq_src = 8'h00;
        bus_write(c_ieoi, 32'h0);
        bus_read(c_istat, d);
        total++; if (d[1:0] !== 2'b00) begin bad++; $display("FAIL single_eoi_state got=%0d exp=0", d[1:0]); end
        tick();
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL single_idle_req got=%0b exp=0", irq_req); end
    endtask

    task automatic test_priority();
        bus_write(c_ier, 32'hFF);
        irq_src = 8'hA4;
        tick();
        tick();
        total++; if (irq_req !== 1'b1 || irq_id !== 3'd2) begin bad++; $display("FAIL prio_first got=%0b/%0d exp=1/2", irq_req, irq_id); end
        pulse_ack();
        bus_write(c_ieoi, 32'h2);
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL prio_eoi_req got=%0b exp=0", irq_req); end
        tick();
        total++; if (irq_req !== 1'b1 || irq_id !== 3'd2) begin bad++; $display("FAIL prio_b2b got=%0b/%0d exp=1/2", irq_req, irq_id); end
        pulse_ack();
        irq_src = 8'hA0;
        bus_write(c_ieoi, 32'h2);
        tick();
        total++; if (irq_req !== 1'b1 || irq_id !== 3'd5) begin bad++; $display("FAIL prio_next got=%0b/%0d exp=1/5", irq_req, irq_id); end
        pulse_ack();
        irq_src = 8'h00;
        bus_write(c_ieoi, 32'h5);
        tick();
    endtask

    task automatic test_eoi_mismatch();
        logic [31:0] d;
        irq_src = 8'h08;
        tick();
        tick();
        total++; if (irq_id !== 3'd3) begin bad++; $display("FAIL mis_id got=%0d exp=3", irq_id); end
        pulse_ack();
        irq_src = 8'h00;
        bus_write(c_ieoi, 32'h4);
        bus_read(c_istat, d);
        total++; if (d !== 32'h32) begin bad++; $display("FAIL mis_wrong_eoi got=%h exp=32", d); end
        bus_write(c_ieoi, 32'h3);
        bus_read(c_istat, d);
        total++; if (d[1:0] !== 2'b00) begin bad++; $display("FAIL mis_right_eoi got=%0d exp=0", d[1:0]); end
    endtask

    task automatic test_masked();
        logic [31:0] d;
        bus_write(c_ier, 32'h00);
        irq_src = 8'hFF;
        tick();
        tick();
        tick();
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL mask_req got=%0b exp=0", irq_req); end
        bus_read(c_ipr, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL mask_ipr got=%h exp=0", d); end
        bus_write(c_ier, 32'h80);
        bus_read(c_ier, d);
        total++; if (d !== 32'h80) begin bad++; $display("FAIL mask_ier got=%h exp=80", d); end
        tick();
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL mask_lat1 got=%0b exp=0", irq_req); end
        tick();
        total++; if (irq_req !== 1'b1 || irq_id !== 3'd7) begin bad++; $display("FAIL mask_unmask got=%0b/%0d exp=1/7", irq_req, irq_id); end
    endtask

    task automatic test_hold_and_reset();
        logic [31:0] d;
        irq_src = 8'h00;
        tick();
        tick();
        tick();
        total++; if (irq_req !== 1'b1 || irq_id !== 3'd7) begin bad++; $display("FAIL hold_req got=%0b/%0d exp=1/7", irq_req, irq_id); end
        pulse_ack();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL midrst_req got=%0b exp=0", irq_req); end
        bus_read(c_ier, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL midrst_ier got=%h exp=0", d); end
        bus_read(c_istat, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL midrst_istat got=%h exp=0", d); end
    endtask

    task automatic test_ignored();
        logic [31:0] d;
        pulse_ack();
        bus_read(c_istat, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL ign_ack_idle got=%h exp=0", d); end
        bus_write(c_ier, 32'h02);
        irq_src = 8'h02;
        tick();
        tick();
        bus_write(c_ieoi, 32'h1);
        bus_read(c_istat, d);
        total++; if (d !== 32'h11) begin bad++; $display("FAIL ign_eoi_req got=%h exp=11", d); end
        bus_write(c_ier, 32'h00);
        total++; if (irq_req !== 1'b1) begin bad++; $display("FAIL ign_ier_clear got=%0b exp=1", irq_req); end
        pulse_ack();
        pulse_ack();
        bus_read(c_istat, d);
        total++; if (d !== 32'h12) begin bad++; $display("FAIL ign_ack_active got=%h exp=12", d); end
        irq_src = 8'h00;
        bus_write(c_ieoi, 32'h1);
        bus_read(c_istat, d);
        total++; if (d[1:0] !== 2'b00) begin bad++; $display("FAIL ign_final_eoi got=%0d exp=0", d[1:0]); end
    endtask

    initial begin
        rst     = 1'b1;
        addr    = 32'h0;
        wdata   = 32'h0;
        wr_en   = 1'b0;
        irq_src = 8'h00;
        irq_ack = 1'b0;
        test_reset();
        test_unmapped();
        test_single();
        test_priority();
        test_eoi_mismatch();
        test_masked();
        test_hold_and_reset();
        test_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
